axi4_lite_slave_regbank: RTL and testbench

AXI4-Lite slave register bank that terminates the AXI4-Lite bus driven by the `axi4_lite_master` controller in our test environment. It provides `G_NB_REGS` word-wide read/write registers with byte-strobe writes and SLVERR on out-of-range addresses. Register contents and per-register write pulses are exported so that DUT logic or bench checkers can observe them. This block is the downstream endpoint of every master transaction and the reference target for master self-tests.

---
 rtl/axi4_lite_pkg.sv | 11 +
 rtl/axi4_lite_addr_decode.sv | 24 ++
 rtl/axi4_lite_slave_regbank.sv | 227 ++++++++++++++++++++++
 tb/tb_axi4_lite_slave_regbank.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel FSM state types.
// The master controller reuses the response constants.
package axi4_lite_pkg;

  localparam logic [1:0] C_AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} t_axi_wr_state;
  typedef enum logic {R_IDLE, R_DATA} t_axi_rd_state;

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Combinational byte-address decode into a register index and an in-range flag.
// The address is in range only when every bit above the index field is zero.
module axi4_lite_addr_decode #(
  parameter int G_ADDR_WIDTH = 32,
  parameter int G_DATA_WIDTH = 32,
  parameter int G_NB_REGS    = 16
) (
  input  logic [G_ADDR_WIDTH-1:0]      i_addr,
  output logic [$clog2(G_NB_REGS)-1:0] o_idx,
  output logic                         o_in_range
);

  localparam int C_LSB   = $clog2(G_DATA_WIDTH / 8);
  localparam int C_IDX_W = $clog2(G_NB_REGS);

  logic w_unused_lsb;

  assign o_idx      = i_addr[C_LSB +: C_IDX_W];
  assign o_in_range = ((i_addr >> (C_LSB + C_IDX_W)) == '0);

  // Sub-word byte offset bits carry no meaning for word registers.
  assign w_unused_lsb = ^i_addr[C_LSB-1:0];

endmodule

// File: rtl/axi4_lite_slave_regbank.sv
// AXI4-Lite slave terminating the bus into G_NB_REGS word registers with byte strobes,
// SLVERR on out-of-range addresses, and exported contents plus per-register write pulses.
module axi4_lite_slave_regbank
  import axi4_lite_pkg::*;
#(
  parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
  parameter int G_AXI4_LITE_DATA_WIDTH = 32,
  parameter int G_NB_REGS              = 16
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_awvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]           i_awaddr,
  input  logic [2:0]                                  i_awprot,
  output logic                                        o_awready,
  input  logic                                        i_wvalid,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]           i_wdata,
  input  logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]         i_wstrb,
  output logic                                        o_wready,
  output logic                                        o_bvalid,
  output logic [1:0]                                  o_bresp,
  input  logic                                        i_bready,
  input  logic                                        i_arvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]           i_araddr,
  input  logic [2:0]                                  i_arprot,
  output logic                                        o_arready,
  output logic                                        o_rvalid,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]           o_rdata,
  output logic [1:0]                                  o_rresp,
  input  logic                                        i_rready,
  output logic [G_NB_REGS*G_AXI4_LITE_DATA_WIDTH-1:0] o_regs_q,
  output logic [G_NB_REGS-1:0]                        o_wr_pulse
);

  localparam int C_AW  = G_AXI4_LITE_ADDR_WIDTH;
  localparam int C_DW  = G_AXI4_LITE_DATA_WIDTH;
  localparam int C_SW  = C_DW / 8;
  localparam int C_IW  = $clog2(G_NB_REGS);

  t_axi_wr_state r_wr_state, w_wr_state_next;
  t_axi_rd_state r_rd_state, w_rd_state_next;

  logic             r_ready_en;
  logic             r_aw_held;
  logic [C_AW-1:0]  r_awaddr;
  logic             r_w_held;
  logic [C_DW-1:0]  r_wdata;
  logic [C_SW-1:0]  r_wstrb;
  logic [C_DW-1:0]  r_regs [G_NB_REGS];
  logic [G_NB_REGS-1:0] r_wr_pulse;
  logic [1:0]       r_bresp;
  logic [C_DW-1:0]  r_rdata;
  logic [1:0]       r_rresp;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_b_hs;
  logic             w_ar_hs;
  logic             w_commit;
  logic [C_AW-1:0]  w_awaddr;
  logic [C_DW-1:0]  w_wdata;
  logic [C_SW-1:0]  w_wstrb;
  logic [C_IW-1:0]  w_aw_idx;
  logic             w_aw_in_range;
  logic [C_IW-1:0]  w_ar_idx;
  logic             w_ar_in_range;
  logic             w_unused_prot;

  assign w_unused_prot = ^{i_awprot, i_arprot};

  // Readies stay low through reset and for the first edge after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ready_en <= 1'b0;
    else          r_ready_en <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_state <= W_IDLE;
      r_rd_state <= R_IDLE;
    end else begin
      r_wr_state <= w_wr_state_next;
      r_rd_state <= w_rd_state_next;
    end
  end

  always_comb begin
    w_wr_state_next = r_wr_state;
    o_awready       = 1'b0;
    o_wready        = 1'b0;
    o_bvalid        = 1'b0;
    w_commit        = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        o_awready = r_ready_en & ~r_aw_held;
        o_wready  = r_ready_en & ~r_w_held;
        w_commit  = (r_aw_held | (i_awvalid & o_awready)) &
                    (r_w_held  | (i_wvalid  & o_wready));
        if (w_commit) w_wr_state_next = W_RESP;
      end
      W_RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) w_wr_state_next = W_IDLE;
      end
      default: w_wr_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    o_arready       = 1'b0;
    o_rvalid        = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        o_arready = r_ready_en;
        if (i_arvalid & r_ready_en) w_rd_state_next = R_DATA;
      end
      R_DATA: begin
        o_rvalid = 1'b1;
        if (i_rready) w_rd_state_next = R_IDLE;
      end
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  assign w_aw_hs = i_awvalid & o_awready;
  assign w_w_hs  = i_wvalid  & o_wready;
  assign w_b_hs  = o_bvalid  & i_bready;
  assign w_ar_hs = i_arvalid & o_arready;

  // A payload arriving in the commit cycle is used directly, bypassing its latch.
  assign w_awaddr = r_aw_held ? r_awaddr : i_awaddr;
  assign w_wdata  = r_w_held  ? r_wdata  : i_wdata;
  assign w_wstrb  = r_w_held  ? r_wstrb  : i_wstrb;

  axi4_lite_addr_decode #(
    .G_ADDR_WIDTH (C_AW),
    .G_DATA_WIDTH (C_DW),
    .G_NB_REGS    (G_NB_REGS)
  ) u_aw_decode (
    .i_addr     (w_awaddr),
    .o_idx      (w_aw_idx),
    .o_in_range (w_aw_in_range)
  );

  axi4_lite_addr_decode #(
    .G_ADDR_WIDTH (C_AW),
    .G_DATA_WIDTH (C_DW),
    .G_NB_REGS    (G_NB_REGS)
  ) u_ar_decode (
    .i_addr     (i_araddr),
    .o_idx      (w_ar_idx),
    .o_in_range (w_ar_in_range)
  );

  // Latches stay set through W_RESP so both channels remain stalled until the B handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aw_held <= 1'b0;
      r_awaddr  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= i_awaddr;
      end else if (w_b_hs) begin
        r_aw_held <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= i_wdata;
        r_wstrb  <= i_wstrb;
      end else if (w_b_hs) begin
        r_w_held <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < G_NB_REGS; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
      r_bresp    <= C_AXI_RESP_OKAY;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        if (w_aw_in_range) begin
          r_bresp <= C_AXI_RESP_OKAY;
          r_wr_pulse[w_aw_idx] <= 1'b1;
          for (int k = 0; k < C_SW; k++) begin
            if (w_wstrb[k]) r_regs[w_aw_idx][k*8 +: 8] <= w_wdata[k*8 +: 8];
          end
        end else begin
          r_bresp <= C_AXI_RESP_SLVERR;
        end
      end
    end
  end

  // Non-blocking update means a same-edge write is not visible to this read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
      r_rresp <= C_AXI_RESP_OKAY;
    end else if (w_ar_hs) begin
      if (w_ar_in_range) begin
        r_rdata <= r_regs[w_ar_idx];
        r_rresp <= C_AXI_RESP_OKAY;
      end else begin
        r_rdata <= '0;
        r_rresp <= C_AXI_RESP_SLVERR;
      end
    end
  end

  for (genvar g = 0; g < G_NB_REGS; g++) begin : g_regs_out
    assign o_regs_q[g*C_DW +: C_DW] = r_regs[g];
  end

  assign o_wr_pulse = r_wr_pulse;
  assign o_bresp    = r_bresp;
  assign o_rdata    = r_rdata;
  assign o_rresp    = r_rresp;

endmodule

// File: tb/tb_axi4_lite_slave_regbank.sv
// Self-checking bench for axi4_lite_slave_regbank: directed scenarios plus randomized
// traffic compared against an array-based model of the register bank.
module tb_axi4_lite_slave_regbank;

  localparam int NREGS = 16;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_awvalid;
  logic [31:0]   i_awaddr;
  logic [2:0]    i_awprot;
  logic          o_awready;
  logic          i_wvalid;
  logic [31:0]   i_wdata;
  logic [3:0]    i_wstrb;
  logic          o_wready;
  logic          o_bvalid;
  logic [1:0]    o_bresp;
  logic          i_bready;
  logic          i_arvalid;
  logic [31:0]   i_araddr;
  logic [2:0]    i_arprot;
  logic          o_arready;
  logic          o_rvalid;
  logic [31:0]   o_rdata;
  logic [1:0]    o_rresp;
  logic          i_rready;
  logic [NREGS*32-1:0] o_regs_q;
  logic [NREGS-1:0]    o_wr_pulse;

  logic [31:0] model [NREGS];
  int nChecks = 0;
  int nErrors = 0;

  axi4_lite_slave_regbank dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_awvalid  (i_awvalid),
    .i_awaddr   (i_awaddr),
    .i_awprot   (i_awprot),
    .o_awready  (o_awready),
    .i_wvalid   (i_wvalid),
    .i_wdata    (i_wdata),
    .i_wstrb    (i_wstrb),
    .o_wready   (o_wready),
    .o_bvalid   (o_bvalid),
    .o_bresp    (o_bresp),
    .i_bready   (i_bready),
    .i_arvalid  (i_arvalid),
    .i_araddr   (i_araddr),
    .i_arprot   (i_arprot),
    .o_arready  (o_arready),
    .o_rvalid   (o_rvalid),
    .o_rdata    (o_rdata),
    .o_rresp    (o_rresp),
    .i_rready   (i_rready),
    .o_regs_q   (o_regs_q),
    .o_wr_pulse (o_wr_pulse)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal, input logic [31:0] newVal,
                                             input logic [3:0] strb);
    logic [31:0] result = 0;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) result = result + (((newVal >> (8*k)) & 32'hFF) << (8*k));
      else         result = result + (((oldVal >> (8*k)) & 32'hFF) << (8*k));
    end
    return result;
  endfunction

  function automatic bit inRange(input logic [31:0] addr);
    return addr < NREGS * 4;
  endfunction

  function automatic int regIndex(input logic [31:0] addr);
    return int'((addr / 4) % NREGS);
  endfunction

  task automatic nextCycle();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < NREGS; i++)
      checkOutput($sformatf("%s reg%0d", tag, i), 64'(o_regs_q[i*32 +: 32]), 64'(model[i]));
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input string tag);
    int cnt = 0;
    int idx = regIndex(addr);
    bit ok  = inRange(addr);
    i_awaddr  = addr;
    i_wdata   = data;
    i_wstrb   = strb;
    i_awvalid = 1'b1;
    i_wvalid  = 1'b1;
    while (!(o_awready && o_wready) && cnt < 20) begin
      nextCycle();
      cnt++;
    end
    if (cnt >= 20) checkOutput({tag, " ready timeout"}, 64'(0), 64'(1));
    nextCycle();
    i_awvalid = 1'b0;
    i_wvalid  = 1'b0;
    if (ok) model[idx] = mergeBytes(model[idx], data, strb);
    checkOutput({tag, " bvalid"}, 64'(o_bvalid), 64'(1));
    checkOutput({tag, " bresp"}, 64'(o_bresp), ok ? 64'(0) : 64'(2));
    checkOutput({tag, " wr_pulse"}, 64'(o_wr_pulse), ok ? 64'(1) << idx : 64'(0));
    checkOutput({tag, " regword"}, 64'(o_regs_q[idx*32 +: 32]), 64'(model[idx]));
    i_bready = 1'b1;
    nextCycle();
    i_bready = 1'b0;
    checkOutput({tag, " bvalid clear"}, 64'(o_bvalid), 64'(0));
    checkOutput({tag, " pulse clear"}, 64'(o_wr_pulse), 64'(0));
    checkOutput({tag, " awready back"}, 64'(o_awready), 64'(1));
  endtask

  task automatic readReg(input logic [31:0] addr, input string tag);
    int cnt = 0;
    bit ok  = inRange(addr);
    i_araddr  = addr;
    i_arvalid = 1'b1;
    while (!o_arready && cnt < 20) begin
      nextCycle();
      cnt++;
    end
    if (cnt >= 20) checkOutput({tag, " arready timeout"}, 64'(0), 64'(1));
    nextCycle();
    i_arvalid = 1'b0;
    checkOutput({tag, " rvalid"}, 64'(o_rvalid), 64'(1));
    checkOutput({tag, " rdata"}, 64'(o_rdata), ok ? 64'(model[regIndex(addr)]) : 64'(0));
    checkOutput({tag, " rresp"}, 64'(o_rresp), ok ? 64'(0) : 64'(2));
    i_rready = 1'b1;
    nextCycle();
    i_rready = 1'b0;
    checkOutput({tag, " rvalid clear"}, 64'(o_rvalid), 64'(0));
    checkOutput({tag, " arready back"}, 64'(o_arready), 64'(1));
  endtask

  // Random mix of reads and writes, with roughly one access in eight out of range.
  task automatic applyStimulus(input int nOps);
    logic [31:0] addr;
    for (int n = 0; n < nOps; n++) begin
      if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h40;
      else addr = 32'($urandom_range(0, NREGS - 1) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        writeReg(addr, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d wr", n));
      else
        readReg(addr, $sformatf("rnd%0d rd", n));
    end
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    i_rst_n = 1'b0;
    i_awvalid = 1'b0; i_awaddr = '0; i_awprot = 3'b010;
    i_wvalid = 1'b0; i_wdata = '0; i_wstrb = '0; i_bready = 1'b0;
    i_arvalid = 1'b0; i_araddr = '0; i_arprot = 3'b001; i_rready = 1'b0;

    repeat (3) @(negedge i_clk);
    checkOutput("rst awready", 64'(o_awready), 64'(0));
    checkOutput("rst wready", 64'(o_wready), 64'(0));
    checkOutput("rst arready", 64'(o_arready), 64'(0));
    checkOutput("rst bvalid", 64'(o_bvalid), 64'(0));
    checkOutput("rst rvalid", 64'(o_rvalid), 64'(0));
    checkOutput("rst rdata", 64'(o_rdata), 64'(0));
    checkOutput("rst resp", 64'({o_bresp, o_rresp}), 64'(0));
    checkOutput("rst wr_pulse", 64'(o_wr_pulse), 64'(0));
    checkAllRegs("rst");

    i_rst_n = 1'b1;
    #1;
    checkOutput("release arready early", 64'(o_arready), 64'(0));
    nextCycle();
    checkOutput("release awready", 64'(o_awready), 64'(1));
    checkOutput("release wready", 64'(o_wready), 64'(1));
    checkOutput("release arready", 64'(o_arready), 64'(1));

    writeReg(32'h08, 32'hDEADBEEF, 4'hF, "wr full");
    checkOutput("wr full const", 64'(o_regs_q[2*32 +: 32]), 64'h0000_0000_DEAD_BEEF);
    readReg(32'h08, "rd full");
    writeReg(32'h08, 32'h11223344, 4'h5, "wr strb5");
    checkOutput("strb5 const", 64'(o_regs_q[2*32 +: 32]), 64'h0000_0000_DE22_BE44);
    readReg(32'h08, "rd strb5");
    writeReg(32'h08, 32'hFFFFFFFF, 4'h0, "wr strb0");

    writeReg(32'h40, 32'hCAFEF00D, 4'hF, "wr oor");
    readReg(32'h1000, "rd oor");
    checkAllRegs("after oor");

    // Address first, data three cycles later, then a four-cycle B stall.
    i_awaddr = 32'h14; i_awvalid = 1'b1;
    checkOutput("split awready", 64'(o_awready), 64'(1));
    nextCycle();
    i_awvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("split aw stall %0d", c), 64'(o_awready), 64'(0));
      checkOutput($sformatf("split wready %0d", c), 64'(o_wready), 64'(1));
      checkOutput($sformatf("split no bvalid %0d", c), 64'(o_bvalid), 64'(0));
      if (c == 2) begin
        i_wdata = 32'h0BADF00D; i_wstrb = 4'hF; i_wvalid = 1'b1;
      end
      nextCycle();
    end
    i_wvalid = 1'b0;
    model[5] = 32'h0BADF00D;
    checkOutput("split bvalid", 64'(o_bvalid), 64'(1));
    checkOutput("split pulse", 64'(o_wr_pulse), 64'(1) << 5);
    checkOutput("split reg", 64'(o_regs_q[5*32 +: 32]), 64'(model[5]));
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      checkOutput($sformatf("bstall bvalid %0d", c), 64'(o_bvalid), 64'(1));
      checkOutput($sformatf("bstall bresp %0d", c), 64'(o_bresp), 64'(0));
      checkOutput($sformatf("bstall readys %0d", c), 64'({o_awready, o_wready}), 64'(0));
      checkOutput($sformatf("bstall pulse %0d", c), 64'(o_wr_pulse), 64'(0));
    end
    i_bready = 1'b1;
    nextCycle();
    i_bready = 1'b0;
    checkOutput("split bvalid clear", 64'(o_bvalid), 64'(0));
    checkOutput("split awready back", 64'(o_awready), 64'(1));

    // Read and write of the same register on the same edge.
    writeReg(32'h0C, 32'hAAAAAAAA, 4'hF, "wr reg3");
    i_araddr = 32'h0C; i_arvalid = 1'b1;
    i_awaddr = 32'h0C; i_wdata = 32'h55555555; i_wstrb = 4'hF;
    i_awvalid = 1'b1; i_wvalid = 1'b1;
    nextCycle();
    i_arvalid = 1'b0; i_awvalid = 1'b0; i_wvalid = 1'b0;
    checkOutput("same edge rvalid", 64'(o_rvalid), 64'(1));
    checkOutput("same edge rdata", 64'(o_rdata), 64'(model[3]));
    checkOutput("same edge bvalid", 64'(o_bvalid), 64'(1));
    model[3] = 32'h55555555;
    i_rready = 1'b1; i_bready = 1'b1;
    nextCycle();
    i_rready = 1'b0; i_bready = 1'b0;
    readReg(32'h0C, "rd reg3 new");

    applyStimulus(40);
    checkAllRegs("after random");

    // Reset while both a write response and read data are outstanding.
    i_awaddr = 32'h04; i_wdata = 32'h12345678; i_wstrb = 4'hF;
    i_awvalid = 1'b1; i_wvalid = 1'b1;
    i_araddr = 32'h08; i_arvalid = 1'b1;
    nextCycle();
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
    checkOutput("pre-abort bvalid", 64'(o_bvalid), 64'(1));
    checkOutput("pre-abort rvalid", 64'(o_rvalid), 64'(1));
    i_rst_n = 1'b0;
    #1;
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    checkOutput("abort bvalid", 64'(o_bvalid), 64'(0));
    checkOutput("abort rvalid", 64'(o_rvalid), 64'(0));
    checkOutput("abort rdata", 64'(o_rdata), 64'(0));
    checkOutput("abort resp", 64'({o_bresp, o_rresp}), 64'(0));
    checkOutput("abort readys", 64'({o_awready, o_wready, o_arready}), 64'(0));
    checkOutput("abort pulse", 64'(o_wr_pulse), 64'(0));
    checkAllRegs("abort");
    nextCycle();
    nextCycle();
    i_rst_n = 1'b1;
    #1;
    checkOutput("rerelease early", 64'(o_arready), 64'(0));
    nextCycle();
    checkOutput("rerelease readys", 64'({o_awready, o_wready, o_arready}), 64'h7);
    readReg(32'h04, "rd after abort");

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
